// File: rtl/multiplier_datapath_taint_track_word_pkg.sv
// Shared multiplier taint package, used by both the control module and this
// datapath.
//   MUL_WIDTH   default operand width.
//   ctrl_s      control-signal bundle (one bit per command). The matching
//               word-taint bundle uses the same struct.
//   CTRL_W      width of that bundle.
//   rs_op_e     the result-register operation selected for a cycle.
package multiplier_datapath_taint_track_word_pkg;

    localparam int MUL_WIDTH = 4;

    typedef struct packed {
        logic mdld;
        logic mrld;
        logic rsclear;
        logic rsload;
        logic rsshr;
        logic product_done;
    } ctrl_s;

    localparam int CTRL_W = $bits(ctrl_s);

    typedef enum logic [1:0] {
        RS_HOLD  = 2'd0,
        RS_CLEAR = 2'd1,
        RS_LOAD  = 2'd2,
        RS_SHR   = 2'd3
    } rs_op_e;

    // Pick exactly one result-register operation: clear > load > shift.
    function automatic rs_op_e rs_select(input logic clr, input logic ld,
                                         input logic shr);
        rs_op_e op;
        op = RS_HOLD;
        if (clr)      op = RS_CLEAR;
        else if (ld)  op = RS_LOAD;
        else if (shr) op = RS_SHR;
        return op;
    endfunction

    // True when two or more result-register commands are asserted together.
    function automatic logic rs_conflict(input logic clr, input logic ld,
                                         input logic shr);
        return (clr & ld) | (clr & shr) | (ld & shr);
    endfunction

endpackage

// File: rtl/multiplier_datapath_taint_track_word_reg.sv
// taint_word_reg: a data word with its 1-bit word taint.
//   clk, rst   clock and asynchronous active-low reset.
//   ld         load enable. When it is high, q <= d and q_t <= d_t.
//   d, d_t     next value and its taint.
//   q, q_t     registered value and its taint. Both hold while ld is low.
// The taint is replaced on a load, not ORed in. A fresh load is the only way
// to clear it.
module taint_word_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             d_t,
    output logic [WIDTH-1:0] q,
    output logic             q_t
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= '0;
            q_t <= 1'b0;
        end else if (ld) begin
            q   <= d;
            q_t <= d_t;
        end
    end

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// multiplier_datapath_taint_track_word: datapath of a shift-add multiplier.
// Every register carries a 1-bit word taint.
//   clk, rst                  clock and asynchronous active-low reset.
//   multiplicand(_t)          operand A and its taint. Latched on mdld.
//   multiplier(_t)            operand B and its taint. Latched on mrld.
//   mdld/mrld/rsclear/rsload/rsshr/productDone (+ _t)
//                             control strobes from the control module, each
//                             with its own taint.
//   multiplierReg(_t)         multiplier register and its taint, sent back to
//                             control combinationally.
//   product(_t)               product captured on productDone, and its taint.
//   product_valid             one-cycle pulse after each capture.
//   protocol_err              sticky flag for illegal command combinations.
//                             Only reset clears it.
// The result register rs is 2*WIDTH+1 bits wide. The extra MSB holds the
// carry out of the add into the upper half. The following right shift then
// brings that carry back into range.
module multiplier_datapath_taint_track_word
    import multiplier_datapath_taint_track_word_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic               mdld,
    input  logic               mdld_t,
    input  logic               mrld,
    input  logic               mrld_t,
    input  logic               rsclear,
    input  logic               rsclear_t,
    input  logic               rsload,
    input  logic               rsload_t,
    input  logic               rsshr,
    input  logic               rsshr_t,
    input  logic               productDone,
    input  logic               productDone_t,
    output logic [WIDTH-1:0]   multiplierReg,
    output logic               multiplierReg_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               product_valid,
    output logic               protocol_err
);

    ctrl_s cmd;
    ctrl_s cmd_t;

    assign cmd   = '{mdld: mdld, mrld: mrld, rsclear: rsclear,
                     rsload: rsload, rsshr: rsshr, product_done: productDone};
    assign cmd_t = '{mdld: mdld_t, mrld: mrld_t, rsclear: rsclear_t,
                     rsload: rsload_t, rsshr: rsshr_t,
                     product_done: productDone_t};

    logic [WIDTH-1:0]   md;
    logic               md_t;
    logic [WIDTH-1:0]   mr;
    logic               mr_t;
    logic [2*WIDTH:0]   rs;
    logic               rs_t;
    logic [WIDTH:0]     upper_sum;
    rs_op_e             rs_op;

    taint_word_reg #(.WIDTH(WIDTH)) u_md (
        .clk (clk),
        .rst (rst),
        .ld  (cmd.mdld),
        .d   (multiplicand),
        .d_t (multiplicand_t | cmd_t.mdld),
        .q   (md),
        .q_t (md_t)
    );

    taint_word_reg #(.WIDTH(WIDTH)) u_mr (
        .clk (clk),
        .rst (rst),
        .ld  (cmd.mrld),
        .d   (multiplier),
        .d_t (multiplier_t | cmd_t.mrld),
        .q   (mr),
        .q_t (mr_t)
    );

    assign multiplierReg   = mr;
    assign multiplierReg_t = mr_t;

    assign rs_op = rs_select(cmd.rsclear, cmd.rsload, cmd.rsshr);

    // The carry is kept. rs[2W] is always 0 before a load, because loads
    // follow a shift or a clear.
    assign upper_sum = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs   <= '0;
            rs_t <= 1'b0;
        end else begin
            unique case (rs_op)
                RS_CLEAR: begin
                    rs   <= '0;
                    rs_t <= cmd_t.rsclear;
                end
                RS_LOAD: begin
                    rs[2*WIDTH:WIDTH] <= upper_sum;
                    rs_t              <= rs_t | md_t | cmd_t.rsload;
                end
                RS_SHR: begin
                    rs   <= rs >> 1;
                    rs_t <= rs_t | cmd_t.rsshr;
                end
                default: begin
                    rs   <= rs;
                    rs_t <= rs_t;
                end
            endcase
        end
    end

    // productDone arrives together with the final shift. rs[2W:1] is the
    // value that shift produces, so the capture does not wait a cycle for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product       <= '0;
            product_t     <= 1'b0;
            product_valid <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            if (cmd.product_done) begin
                product   <= rs[2*WIDTH:1];
                product_t <= rs_t | cmd_t.rsshr | cmd_t.product_done;
            end
            product_valid <= cmd.product_done;
            protocol_err  <= protocol_err
                           | rs_conflict(cmd.rsclear, cmd.rsload, cmd.rsshr)
                           | (cmd.product_done & ~cmd.rsshr);
        end
    end

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Testbench for multiplier_datapath_taint_track_word with WIDTH=4.
// The bench plays the role of the control module. The reference model
// computes the product as A*B. It computes the product taint from the set of
// taint sources that take part in one operation.
module tb_multiplier_datapath_taint_track_word;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   multiplicand, multiplier;
    logic           multiplicand_t, multiplier_t;
    logic           mdld, mdld_t, mrld, mrld_t;
    logic           rsclear, rsclear_t, rsload, rsload_t;
    logic           rsshr, rsshr_t, productDone, productDone_t;
    logic [W-1:0]   multiplierReg;
    logic           multiplierReg_t;
    logic [2*W-1:0] product;
    logic           product_t;
    logic           product_valid;
    logic           protocol_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .multiplicand    (multiplicand),
        .multiplicand_t  (multiplicand_t),
        .multiplier      (multiplier),
        .multiplier_t    (multiplier_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .productDone     (productDone),
        .productDone_t   (productDone_t),
        .multiplierReg   (multiplierReg),
        .multiplierReg_t (multiplierReg_t),
        .product         (product),
        .product_t       (product_t),
        .product_valid   (product_valid),
        .protocol_err    (protocol_err)
    );

    // Count valid pulses away from the active edge.
    always @(negedge clk) if (product_valid === 1'b1) valid_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
        rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
        rsshr = 0; rsshr_t = 0; productDone = 0; productDone_t = 0;
        multiplicand_t = 0; multiplier_t = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one full operation: clear plus operand loads, then for each bit
    // a shift followed by an add when that bit of B is set, then the final
    // shift with productDone. Returns at #1 after the capture edge.
    task automatic do_mult(input logic [W-1:0] a, input logic a_t,
                           input logic ad_t, input logic [W-1:0] b,
                           input logic b_t, input logic bd_t,
                           input logic clr_t, input logic ld_t,
                           input logic sh_t, input logic dn_t);
        idle_inputs();
        multiplicand = a; multiplicand_t = a_t; mdld = 1; mdld_t = ad_t;
        multiplier = b; multiplier_t = b_t; mrld = 1; mrld_t = bd_t;
        rsclear = 1; rsclear_t = clr_t;
        step();
        idle_inputs();
        for (int i = 0; i < W; i++) begin
            rsshr = 1; rsshr_t = sh_t;
            step();
            rsshr = 0; rsshr_t = 0;
            if (b[i]) begin
                rsload = 1; rsload_t = ld_t;
                step();
                rsload = 0; rsload_t = 0;
            end
        end
        rsshr = 1; rsshr_t = sh_t; productDone = 1; productDone_t = dn_t;
        step();
        idle_inputs();
    endtask

    // Reference model: the product taint combines every taint source of the
    // operation. The multiplicand taint and the add taint count only if at
    // least one add happened, that is, if B is non-zero.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[2*W-1:0];
    endfunction

    function automatic logic ref_taint(input logic [W-1:0] b, input logic a_t,
                                       input logic ad_t, input logic clr_t,
                                       input logic ld_t, input logic sh_t,
                                       input logic dn_t);
        return clr_t | sh_t | dn_t | ((b != 0) & (a_t | ad_t | ld_t));
    endfunction

    task automatic mult_and_check(input string tag, input logic [W-1:0] a,
                                  input logic a_t, input logic ad_t,
                                  input logic [W-1:0] b, input logic b_t,
                                  input logic bd_t, input logic clr_t,
                                  input logic ld_t, input logic sh_t,
                                  input logic dn_t);
        int v0;
        v0 = valid_cnt;
        do_mult(a, a_t, ad_t, b, b_t, bd_t, clr_t, ld_t, sh_t, dn_t);
        check({tag, ".valid"}, product_valid, 1);
        check({tag, ".product"}, product, ref_prod(a, b));
        check({tag, ".product_t"}, product_t,
              ref_taint(b, a_t, ad_t, clr_t, ld_t, sh_t, dn_t));
        check({tag, ".mr"}, multiplierReg, b);
        check({tag, ".mr_t"}, multiplierReg_t, b_t | bd_t);
        step();
        check({tag, ".valid_drop"}, product_valid, 0);
        step();
        check({tag, ".pulses"}, valid_cnt - v0, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [9:0]   rt;
        int           v0;

        // Reset state
        rst = 1'b0;
        multiplicand = 0; multiplier = 0;
        idle_inputs();
        step(); step();
        check("rst.product", product, 0);
        check("rst.product_t", product_t, 0);
        check("rst.valid", product_valid, 0);
        check("rst.err", protocol_err, 0);
        check("rst.mr", multiplierReg, 0);
        check("rst.mr_t", multiplierReg_t, 0);
        rst = 1'b1;
        step();

        // Directed operations
        mult_and_check("13x11", 13, 0, 0, 11, 0, 0, 0, 0, 0, 0);
        mult_and_check("15x15", 15, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        check("15x15.err", protocol_err, 0);
        mult_and_check("9tx0", 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mult_and_check("9tx1", 9, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        mult_and_check("clr_t1", 6, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        mult_and_check("clr_t0", 6, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        mult_and_check("mrld_t", 3, 0, 0, 7, 0, 1, 0, 0, 0, 0);

        // Random operations, taint sources each set with probability 1/4
        for (int k = 0; k < 16; k++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            for (int j = 0; j < 10; j++) rt[j] = ($urandom_range(0, 3) == 0);
            mult_and_check("rand", ra, rt[0], rt[1], rb, rt[2], rt[3],
                           rt[4], rt[5], rt[6], rt[7]);
        end
        check("rand.err", protocol_err, 0);

        // rsload + rsshr together: only the add happens, and the error sticks
        idle_inputs();
        multiplicand = 5; mdld = 1; rsclear = 1;
        step();
        idle_inputs();
        rsload = 1; rsshr = 1;
        step();
        idle_inputs();
        check("conflict.err", protocol_err, 1);
        rsshr = 1; productDone = 1;
        step();
        idle_inputs();
        check("conflict.product", product, 8'd40);
        step(); step(); step();
        check("conflict.sticky", protocol_err, 1);

        // Reset in the middle of a multiply, after two adds
        idle_inputs();
        multiplicand = 15; mdld = 1; multiplier = 15; mrld = 1; rsclear = 1;
        step();
        idle_inputs();
        rsshr = 1; step(); rsshr = 0;
        rsload = 1; step(); rsload = 0;
        rsshr = 1; step(); rsshr = 0;
        rsload = 1; step(); rsload = 0;
        rst = 1'b0;
        #1;
        check("midrst.product", product, 0);
        check("midrst.product_t", product_t, 0);
        check("midrst.valid", product_valid, 0);
        check("midrst.err", protocol_err, 0);
        check("midrst.mr", multiplierReg, 0);
        check("midrst.mr_t", multiplierReg_t, 0);
        v0 = valid_cnt;
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("midrst.no_valid", valid_cnt - v0, 0);
        check("midrst.product_hold", product, 0);

        // productDone without rsshr is a protocol error
        productDone = 1;
        step();
        idle_inputs();
        check("done_noshr.err", protocol_err, 1);
        check("done_noshr.valid", product_valid, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
